uart_rx_fifo_ctrl: RTL and testbench

- Receive-side controller between `uart_rx` and the CPU bus.
- Converts `uart_rx`'s sticky `rx_ready` into one push per received byte and buffers bytes in a FIFO.
- Exposes a 2-register memory-mapped interface (data, status/control) with an interrupt request, so the 6502 never misses bytes arriving back-to-back at 115200 baud.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_fifo_ctrl_fifo.sv | 60 ++++++
 rtl/uart_rx_fifo_ctrl.sv | 123 ++++++++++++
 tb/tb_uart_rx_fifo_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared register map and status layout for the UART receive FIFO controller.
package uart_pkg;

    localparam logic REG_DATA = 1'b0;
    localparam logic REG_STAT = 1'b1;

    localparam int ST_AVAIL   = 0;
    localparam int ST_OVERRUN = 1;
    localparam int ST_FULL    = 2;
    localparam int ST_HALF    = 3;
    localparam int ST_IRQEN   = 7;

    localparam int CTRL_W1C_OVR = 1;

    // Field order matches the ST_* bit positions above (MSB first).
    typedef struct packed {
        logic       irq_en;
        logic [2:0] rsvd;
        logic       half;
        logic       full;
        logic       overrun;
        logic       avail;
    } status_t;

endpackage

// File: rtl/uart_rx_fifo_ctrl_fifo.sv
// Synchronous FIFO with combinational head output and a separate occupancy counter.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A write while full is legal only when the head leaves on the same edge.
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en & ~rd_en) begin
                count <= count + 1'b1;
            end else if (rd_en & ~wr_en) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// Receive-side controller: edge-detects uart_rx's sticky ready flag, buffers bytes,
// and exposes DATA and STATUS/CTRL registers plus a level interrupt to the CPU.
module uart_rx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_ready,
    input  logic [7:0]           rx_data,
    input  logic                 cs,
    input  logic                 we,
    input  logic                 addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata,
    output logic                 irq,
    output logic [CNT_WIDTH-1:0] fifo_count
);

    logic                 rdy_prev;
    logic                 overrun;
    logic                 irq_en;
    logic                 push;
    logic                 rd_data;
    logic                 rd_stat;
    logic                 wr_ctrl;
    logic                 pop;
    logic                 fifo_push;
    logic                 drop;
    logic                 full;
    logic                 empty;
    logic                 half;
    logic [7:0]           head;
    logic [CNT_WIDTH-1:0] count_nxt;
    logic                 ovr_nxt;
    logic                 ien_nxt;
    status_t              status;
    logic                 unused_wdata;

    assign unused_wdata = ^{wdata[6:2], wdata[0]};

    // rdy_prev resets high so a flag already asserted at reset release is ignored.
    assign push      = rx_ready & ~rdy_prev;
    assign rd_data   = cs & ~we & (addr == REG_DATA);
    assign rd_stat   = cs & ~we & (addr == REG_STAT);
    assign wr_ctrl   = cs &  we & (addr == REG_STAT);
    assign pop       = rd_data & ~empty;
    assign fifo_push = push & (~full | pop);
    assign drop      = push & full & ~pop;
    assign half      = (fifo_count >= CNT_WIDTH'(FIFO_DEPTH / 2));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (pop),
        .din   (rx_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_comb begin
        status         = '0;
        status.irq_en  = irq_en;
        status.half    = half;
        status.full    = full;
        status.overrun = overrun;
        status.avail   = ~empty;
    end

    always_comb begin
        count_nxt = fifo_count;
        if (fifo_push & ~pop) begin
            count_nxt = fifo_count + 1'b1;
        end else if (pop & ~fifo_push) begin
            count_nxt = fifo_count - 1'b1;
        end
    end

    // Overrun set is applied after the W1C so a same-cycle drop keeps the flag.
    always_comb begin
        ien_nxt = irq_en;
        ovr_nxt = overrun;
        if (wr_ctrl) begin
            ien_nxt = wdata[ST_IRQEN];
            if (wdata[CTRL_W1C_OVR]) begin
                ovr_nxt = 1'b0;
            end
        end
        if (drop) begin
            ovr_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_prev <= 1'b1;
            overrun  <= 1'b0;
            irq_en   <= 1'b0;
            irq      <= 1'b0;
            rdata    <= 8'h00;
        end else begin
            rdy_prev <= rx_ready;
            overrun  <= ovr_nxt;
            irq_en   <= ien_nxt;
            irq      <= ien_nxt & ((count_nxt != '0) | ovr_nxt);
            if (rd_data) begin
                rdata <= empty ? 8'h00 : head;
            end else if (rd_stat) begin
                rdata <= status;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Randomized and directed bench with a queue-based reference model and a read scoreboard.
module tb_uart_rx_fifo_ctrl;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_ready;
    logic [7:0]    rx_data;
    logic          cs;
    logic          we;
    logic          addr;
    logic [7:0]    wdata;
    logic [7:0]    rdata;
    logic          irq;
    logic [CW-1:0] fifo_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    bit         m_prev;
    bit         m_ovr;
    bit         m_ien;
    bit         m_irq;
    bit         rd_vld;
    bit         m_push;
    logic [7:0] m_st;

    always #5 clk = ~clk;

    uart_rx_fifo_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .cs         (cs),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .irq        (irq),
        .fifo_count (fifo_count)
    );

    // Model: each clock edge applies one cycle of register-level behaviour to a byte queue.
    always @(posedge clk) begin
        rd_vld = 1'b0;
        if (rst) begin
            m_q.delete();
            m_ovr  = 1'b0;
            m_ien  = 1'b0;
            m_prev = 1'b1;
            m_irq  = 1'b0;
            exp_q.push_back(8'h00);
            rd_vld = 1'b1;
        end else begin
            m_push = rx_ready && !m_prev;
            m_prev = rx_ready;
            if (cs && !we) begin
                rd_vld = 1'b1;
                if (addr == 1'b0) begin
                    if (m_q.size() > 0) exp_q.push_back(m_q.pop_front());
                    else                exp_q.push_back(8'h00);
                end else begin
                    m_st = {m_ien, 3'b000, m_q.size() >= DEPTH / 2, m_q.size() == DEPTH,
                            m_ovr, m_q.size() != 0};
                    exp_q.push_back(m_st);
                end
            end
            if (cs && we && addr) begin
                m_ien = wdata[7];
                if (wdata[1]) m_ovr = 1'b0;
            end
            if (m_push) begin
                if (m_q.size() < DEPTH) m_q.push_back(rx_data);
                else                    m_ovr = 1'b1;
            end
            m_irq = m_ien && (m_q.size() != 0 || m_ovr);
        end
    end

    // Monitor: compares DUT outputs against the model shortly after every edge.
    always @(posedge clk) begin
        #1;
        checks++;
        if (fifo_count !== CW'(m_q.size())) begin
            errors++;
            $display("FAIL count t=%0t got %0d exp %0d", $time, fifo_count, m_q.size());
        end
        checks++;
        if (irq !== m_irq) begin
            errors++;
            $display("FAIL irq t=%0t got %0b exp %0b", $time, irq, m_irq);
        end
        if (rd_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rdata t=%0t scoreboard empty", $time);
            end else begin
                automatic logic [7:0] e = exp_q.pop_front();
                if (rdata !== e) begin
                    errors++;
                    $display("FAIL rdata t=%0t got %02h exp %02h", $time, rdata, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic byte_in(input logic [7:0] b);
        rx_ready = 1'b0;
        @(negedge clk);
        rx_ready = 1'b1;
        rx_data  = b;
        @(negedge clk);
    endtask

    task automatic rd(input logic a, output logic [7:0] v);
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        cs = 1'b0;
        v = rdata;
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    logic [7:0] v;

    initial begin
        rst = 1'b1; rx_ready = 1'b1; rx_data = 8'h99;
        cs = 1'b0; we = 1'b0; addr = 1'b0; wdata = 8'h00;
        idle(2);
        rst = 1'b0;
        idle(5);
        chk("reset_count", fifo_count, 0);
        chk("reset_irq", irq, 0);
        rd(1'b1, v); chk("reset_status", v, 8'h00);

        byte_in(8'h41); byte_in(8'h42); byte_in(8'h43);
        chk("count3", fifo_count, 3);
        rd(1'b0, v); chk("rd_41", v, 8'h41);
        rd(1'b0, v); chk("rd_42", v, 8'h42);
        rd(1'b0, v); chk("rd_43", v, 8'h43);
        rd(1'b0, v); chk("rd_empty", v, 8'h00);
        chk("count0", fifo_count, 0);

        for (int i = 0; i < 17; i++) byte_in(8'(8'h10 + i));
        rd(1'b1, v); chk("status_full_ovr", v, 8'h0F);
        wr(1'b1, 8'h02);
        rd(1'b1, v); chk("status_w1c", v, 8'h0D);
        for (int i = 0; i < 16; i++) begin
            rd(1'b0, v); chk("rd_full_seq", v, 8'(8'h10 + i));
        end

        wr(1'b1, 8'h80);
        rx_ready = 1'b0;
        @(negedge clk);
        chk("irq_before_push", irq, 0);
        rx_ready = 1'b1; rx_data = 8'h55;
        @(negedge clk);
        chk("irq_after_push", irq, 1);
        chk("count_after_push", fifo_count, 1);
        rd(1'b0, v); chk("rd_55", v, 8'h55);
        chk("irq_after_pop", irq, 0);

        for (int i = 0; i < 16; i++) byte_in(8'(8'hA0 + i));
        rx_ready = 1'b0;
        @(negedge clk);
        rx_ready = 1'b1; rx_data = 8'hEE;
        cs = 1'b1; we = 1'b0; addr = 1'b0;
        @(negedge clk);
        cs = 1'b0;
        chk("simul_head", rdata, 8'hA0);
        chk("simul_count", fifo_count, 16);
        rd(1'b1, v); chk("simul_status", v, 8'h8D);
        for (int i = 1; i < 16; i++) begin
            rd(1'b0, v); chk("simul_seq", v, 8'(8'hA0 + i));
        end
        rd(1'b0, v); chk("simul_last", v, 8'hEE);

        for (int i = 0; i < 16; i++) byte_in(8'(i));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_count", fifo_count, 0);
        chk("rst_mid_irq", irq, 0);
        chk("rst_mid_rdata", rdata, 8'h00);

        // Random phase: alternating fill-heavy and drain-heavy windows.
        for (int c = 0; c < 3000; c++) begin
            automatic int rd_pct = ((c / 300) % 2 == 0) ? 8 : 45;
            rst = ($urandom_range(0, 399) == 0);
            if (rx_ready && $urandom_range(0, 3) == 0) begin
                rx_ready = 1'b0;
            end else if (!rx_ready && $urandom_range(0, 1) == 0) begin
                rx_ready = 1'b1;
                rx_data  = 8'($urandom);
            end
            if ($urandom_range(0, 99) < rd_pct) begin
                cs = 1'b1; we = 1'b0; addr = ($urandom_range(0, 3) == 0);
            end else if ($urandom_range(0, 19) == 0) begin
                cs = 1'b1; we = 1'b1; addr = 1'($urandom); wdata = 8'($urandom);
            end else begin
                cs = 1'b0; we = 1'($urandom); addr = 1'($urandom);
            end
            @(negedge clk);
        end
        rst = 1'b0; cs = 1'b0;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
